// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory with one-cycle read latency.
// Grants are combinational; the response is steered back to the owner one cycle after acceptance.
module mem_arbiter #(
    parameter int unsigned p_dmem_pri = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq_val,
    output logic        ireq_rdy,
    input  logic [31:0] ireq_addr,
    output logic        iresp_val,
    output logic [31:0] iresp_data,
    input  logic        dreq_val,
    output logic        dreq_rdy,
    input  logic        dreq_type,
    input  logic [31:0] dreq_addr,
    input  logic [31:0] dreq_wdata,
    output logic        dresp_val,
    output logic [31:0] dresp_rdata,
    output logic        memreq_val,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_wdata,
    input  logic [31:0] memresp_rdata
);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic last_grant_q, last_grant_d;
    logic infl_vld_q, infl_vld_d;
    logic infl_own_q, infl_own_d;
    logic infl_st_q, infl_st_d;
    logic gnt_i, gnt_d;

    // Grants are forced low while reset is held so nothing reaches memory.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst) begin
            if (p_dmem_pri != 0) begin
                gnt_d = dreq_val;
                gnt_i = ireq_val & ~dreq_val;
            end else if (ireq_val && dreq_val) begin
                gnt_i = (last_grant_q == OWN_D);
                gnt_d = ~gnt_i;
            end else begin
                gnt_i = ireq_val;
                gnt_d = dreq_val;
            end
        end
    end

    assign ireq_rdy     = gnt_i;
    assign dreq_rdy     = gnt_d;
    assign memreq_val   = gnt_i | gnt_d;
    assign memreq_type  = gnt_d & dreq_type;
    assign memreq_addr  = gnt_d ? dreq_addr : (gnt_i ? ireq_addr : 32'h0);
    assign memreq_wdata = gnt_d ? dreq_wdata : 32'h0;

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_i) begin
            last_grant_d = OWN_I;
        end else if (gnt_d) begin
            last_grant_d = OWN_D;
        end
        infl_vld_d = gnt_i | gnt_d;
        infl_own_d = gnt_d;
        // Stores answer with zero, so the in-flight slot remembers the type.
        infl_st_d  = gnt_d & dreq_type;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= OWN_D;
            infl_vld_q   <= 1'b0;
            infl_own_q   <= OWN_I;
            infl_st_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            infl_vld_q   <= infl_vld_d;
            infl_own_q   <= infl_own_d;
            infl_st_q    <= infl_st_d;
        end
    end

    assign iresp_val   = infl_vld_q & (infl_own_q == OWN_I);
    assign dresp_val   = infl_vld_q & (infl_own_q == OWN_D);
    assign iresp_data  = iresp_val ? memresp_rdata : 32'h0;
    assign dresp_rdata = (dresp_val && !infl_st_q) ? memresp_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 is data-priority; each has its own memory model.
module tb_mem_arbiter;

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ireq_val      [2];
    logic        ireq_rdy      [2];
    logic [31:0] ireq_addr     [2];
    logic        iresp_val     [2];
    logic [31:0] iresp_data    [2];
    logic        dreq_val      [2];
    logic        dreq_rdy      [2];
    logic        dreq_type     [2];
    logic [31:0] dreq_addr     [2];
    logic [31:0] dreq_wdata    [2];
    logic        dresp_val     [2];
    logic [31:0] dresp_rdata   [2];
    logic        memreq_val    [2];
    logic        memreq_type   [2];
    logic [31:0] memreq_addr   [2];
    logic [31:0] memreq_wdata  [2];

    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t q0[$];
    exp_t q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'h0000_0513 : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem_rdata;
        bit          st_v;
        bit   [31:0] st_a;
        bit   [31:0] st_d;

        mem_arbiter #(.p_dmem_pri(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .ireq_val     (ireq_val[g]),
            .ireq_rdy     (ireq_rdy[g]),
            .ireq_addr    (ireq_addr[g]),
            .iresp_val    (iresp_val[g]),
            .iresp_data   (iresp_data[g]),
            .dreq_val     (dreq_val[g]),
            .dreq_rdy     (dreq_rdy[g]),
            .dreq_type    (dreq_type[g]),
            .dreq_addr    (dreq_addr[g]),
            .dreq_wdata   (dreq_wdata[g]),
            .dresp_val    (dresp_val[g]),
            .dresp_rdata  (dresp_rdata[g]),
            .memreq_val   (memreq_val[g]),
            .memreq_type  (memreq_type[g]),
            .memreq_addr  (memreq_addr[g]),
            .memreq_wdata (memreq_wdata[g]),
            .memresp_rdata(mem_rdata)
        );

        always @(posedge clk) begin
            if (memreq_val[g]) begin
                if (memreq_type[g]) begin
                    st_v <= 1'b1;
                    st_a <= memreq_addr[g];
                    st_d <= memreq_wdata[g];
                end
                mem_rdata <= (st_v && st_a == memreq_addr[g]) ? st_d : rom(memreq_addr[g]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int g);
        exp_t e;
        int   qs;
        if (iresp_val[g] || dresp_val[g]) begin
            chk("resp_on_one_port", {31'h0, iresp_val[g] & dresp_val[g]}, 32'h0);
            qs = (g == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: inst %0d got i=%0b d=%0b, expected none (cycle %0d)",
                         g, iresp_val[g], dresp_val[g], cyc);
            end else begin
                e = (g == 0) ? q0.pop_front() : q1.pop_front();
                chk("resp_port", {31'h0, dresp_val[g]}, {31'h0, e.port});
                chk("resp_data", dresp_val[g] ? dresp_rdata[g] : iresp_data[g], e.data);
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                chk("nonowner_data", dresp_val[g] ? iresp_data[g] : dresp_rdata[g], 32'h0);
            end
        end
    endtask

    task automatic step(input int g,
                        input bit iv, input logic [31:0] ia,
                        input bit dv, input bit dt, input logic [31:0] da, input logic [31:0] dw,
                        input bit exp_i, input bit exp_d, input logic [31:0] exp_data);
        exp_t e;
        @(negedge clk);
        ireq_val[g]   = iv;
        ireq_addr[g]  = ia;
        dreq_val[g]   = dv;
        dreq_type[g]  = dt;
        dreq_addr[g]  = da;
        dreq_wdata[g] = dw;
        #1;
        chk("ireq_rdy", {31'h0, ireq_rdy[g]}, {31'h0, exp_i});
        chk("dreq_rdy", {31'h0, dreq_rdy[g]}, {31'h0, exp_d});
        chk("memreq_val", {31'h0, memreq_val[g]}, {31'h0, exp_i | exp_d});
        if (exp_i) begin
            chk("memreq_addr_i", memreq_addr[g], ia);
            chk("memreq_type_i", {31'h0, memreq_type[g]}, 32'h0);
        end
        if (exp_d) begin
            chk("memreq_addr_d", memreq_addr[g], da);
            chk("memreq_type_d", {31'h0, memreq_type[g]}, {31'h0, dt});
            chk("memreq_wdata", memreq_wdata[g], dw);
        end
        if (exp_i || exp_d) begin
            e.cyc  = cyc + 1;
            e.port = exp_d;
            e.data = exp_data;
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic idle(input int g);
        step(g, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int g = 0; g < 2; g++) begin
            ireq_val[g]   = 1'b1;
            ireq_addr[g]  = 32'h0000_0100;
            dreq_val[g]   = 1'b1;
            dreq_type[g]  = 1'b0;
            dreq_addr[g]  = 32'h0000_0300;
            dreq_wdata[g] = 32'h0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 2; g++) mon(g);
            end
        join_none

        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ireq_rdy", {31'h0, ireq_rdy[g]}, 32'h0);
            chk("rst_dreq_rdy", {31'h0, dreq_rdy[g]}, 32'h0);
            chk("rst_memreq_val", {31'h0, memreq_val[g]}, 32'h0);
            chk("rst_iresp_val", {31'h0, iresp_val[g]}, 32'h0);
            chk("rst_dresp_val", {31'h0, dresp_val[g]}, 32'h0);
        end
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            ireq_val[g] = 1'b0;
            dreq_val[g] = 1'b0;
        end

        // Round-robin contention straight out of reset: I, D, I, D.
        step(0, 1, 32'h100, 1, 0, 32'h300, 32'h0, 1, 0, 32'hC0DE_0100);
        step(0, 1, 32'h104, 1, 0, 32'h300, 32'h0, 0, 1, 32'hC0DE_0300);
        step(0, 1, 32'h104, 1, 0, 32'h304, 32'h0, 1, 0, 32'hC0DE_0104);
        step(0, 1, 32'h108, 1, 0, 32'h304, 32'h0, 0, 1, 32'hC0DE_0304);
        step(0, 1, 32'h108, 0, 0, 32'h0,   32'h0, 1, 0, 32'hC0DE_0108);

        // Lone fetch.
        step(0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0000_0513);
        idle(0);

        // Store then load of the same word.
        step(0, 0, 32'h0, 1, 1, 32'h2000, 32'hDEAD_BEEF, 0, 1, 32'h0);
        step(0, 0, 32'h0, 1, 0, 32'h2000, 32'h0,         0, 1, 32'hDEAD_BEEF);

        // Idle gaps must not disturb the round-robin pointer (last grant = D).
        idle(0); idle(0); idle(0);
        step(0, 1, 32'h10C, 1, 0, 32'h308, 32'h0, 1, 0, 32'hC0DE_010C);
        step(0, 1, 32'h110, 1, 0, 32'h308, 32'h0, 0, 1, 32'hC0DE_0308);
        idle(0); idle(0);
        step(0, 1, 32'h110, 1, 0, 32'h30C, 32'h0, 1, 0, 32'hC0DE_0110);
        step(0, 0, 32'h0,   1, 0, 32'h30C, 32'h0, 0, 1, 32'hC0DE_030C);
        idle(0);

        // Data-priority instance: D wins while valid, then the held fetch goes.
        step(1, 1, 32'h400, 1, 0, 32'h500, 32'h0, 0, 1, 32'hC0DE_0500);
        step(1, 1, 32'h400, 1, 0, 32'h504, 32'h0, 0, 1, 32'hC0DE_0504);
        step(1, 1, 32'h400, 1, 0, 32'h508, 32'h0, 0, 1, 32'hC0DE_0508);
        step(1, 1, 32'h400, 0, 0, 32'h0,   32'h0, 1, 0, 32'hC0DE_0400);
        idle(1);
        idle(0);

        // Reset the cycle after a fetch is accepted; its response is dropped.
        step(0, 1, 32'h114, 0, 0, 32'h0, 32'h0, 1, 0, 32'hC0DE_0114);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        ireq_val[0]   = 1'b1;
        ireq_addr[0]  = 32'h118;
        q0.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("midrst_iresp_val", {31'h0, iresp_val[0]}, 32'h0);
            chk("midrst_ireq_rdy", {31'h0, ireq_rdy[0]}, 32'h0);
            chk("midrst_memreq_val", {31'h0, memreq_val[0]}, 32'h0);
        end
        rst         = 1'b1;
        ireq_val[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("postrst_iresp_val", {31'h0, iresp_val[0]}, 32'h0);
        chk("postrst_dresp_val", {31'h0, dresp_val[0]}, 32'h0);
        step(0, 1, 32'h11C, 1, 0, 32'h310, 32'h0, 1, 0, 32'hC0DE_011C);
        idle(0);
        idle(0);

        chk("sb0_drained", 32'(q0.size()), 32'h0);
        chk("sb1_drained", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter p_dmem_pri, default 0, meaning 0 = round-robin arbitration and 1 = data port always wins.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ireq_val  input  1  instruction-fetch request valid.
REQ-005 The block SHALL have port ireq_rdy  output  1  instruction request accepted this cycle.
REQ-006 The block SHALL have port ireq_addr  input  32  fetch byte address.
REQ-007 The block SHALL have port iresp_val  output  1  fetch response valid.
REQ-008 The block SHALL have port iresp_data  output  32  fetched instruction word.
REQ-009 The block SHALL have port dreq_val  input  1  data request valid.
REQ-010 The block SHALL have port dreq_rdy  output  1  data request accepted this cycle.
REQ-011 The block SHALL have port dreq_type  input  1  0 = load, 1 = store.
REQ-012 The block SHALL have ports dreq_addr and dreq_wdata  input  32 each  data address and store data.
REQ-013 The block SHALL have port dresp_val  output  1  data response valid.
REQ-014 The block SHALL have port dresp_rdata  output  32  load data; 0 for stores.
REQ-015 The block SHALL have ports memreq_val (output 1), memreq_type (output 1), memreq_addr (output 32), memreq_wdata (output 32)  single-port memory request.
REQ-016 The block SHALL have port memresp_rdata  input  32  memory read data, valid exactly one cycle after the request.

Function
REQ-017 At most one request SHALL be forwarded to memory per cycle; memreq_* SHALL combinationally mirror the granted requester's fields, with memreq_type = 0 for fetches.
REQ-018 ireq_rdy/dreq_rdy SHALL be combinational, at most one high per cycle, and high only when the matching *_val is high.
REQ-019 A request SHALL be accepted on a rising edge where val and rdy are both high; a requester holds val and fields stable until accepted.
REQ-020 Arbitration when p_dmem_pri = 0: if only one port is valid it is granted; if both are valid, the port not granted most recently (last_grant register) wins.
REQ-021 Arbitration when p_dmem_pri = 1: the data port SHALL win whenever dreq_val is high.
REQ-022 last_grant SHALL update only on an accepted request; idle cycles SHALL leave it unchanged.
REQ-023 A 2-bit in-flight register {valid, owner} SHALL capture the accepted request each cycle; the next cycle, the response is routed to the owner.
REQ-024 Response latency SHALL be exactly one cycle after acceptance; iresp_data/dresp_rdata SHALL equal memresp_rdata in the response cycle.
REQ-025 Back-to-back acceptance SHALL be supported: a new request may be granted in the same cycle a prior response is returned (throughput 1/cycle).
REQ-026 A store SHALL produce dresp_val = 1 with dresp_rdata = 0 one cycle after acceptance.
REQ-027 A response SHALL never be presented on both ports in one cycle; the non-owner *_resp_val SHALL be 0 and its data 0.
REQ-028 With both ports continuously valid and p_dmem_pri = 0, grants SHALL strictly alternate, so no requester waits more than one cycle.

Reset
REQ-029 While rst = 0: iresp_val = dresp_val = 0, in-flight valid = 0, last_grant = data (so the first contended grant goes to instruction), ireq_rdy = dreq_rdy = 0, memreq_val = 0.
REQ-030 Reset asserted mid-transaction SHALL discard the in-flight response; no *_resp_val is asserted on the first cycle after reset release.

Verification
REQ-031 The bench SHALL cover: ireq_val = 1, addr 0x00000200, memory returns 0x00000513 -> ireq_rdy = 1 at cycle 0, iresp_val = 1 and iresp_data = 0x00000513 at cycle 1, dresp_val = 0.
REQ-032 The bench SHALL cover: both ports valid for 4 cycles after reset, p_dmem_pri = 0 -> grant order I, D, I, D; responses follow one cycle later on matching ports.
REQ-033 The bench SHALL cover: a store to 0x00002000 with wdata 0xdeadbeef, then a load from 0x00002000 -> memreq_type = 1 then 0; the load response is dresp_rdata = 0xdeadbeef; the store response is dresp_rdata = 0.
REQ-034 The bench SHALL cover: p_dmem_pri = 1 with both ports valid for 3 cycles -> dreq_rdy = 1 all 3 cycles, ireq_rdy = 0, then an instruction grant on cycle 4 once dreq_val drops.
REQ-035 The bench SHALL cover: rst pulsed low in the cycle after a fetch is accepted -> iresp_val = 0 throughout reset and on the first post-reset cycle.
REQ-036 The bench SHALL cover: idle cycles (no val) between two contended cycles -> last_grant is unchanged by the idle cycles and alternation resumes correctly.
